// File: rtl/pc_gen_pkg.sv
// Shared definitions for the PC generator: FSM encodings, the NOP word and
// the pc_src encodings agreed with the branch controller.
package pc_gen_pkg;

  localparam logic [1:0] PCG_BOOT  = 2'd0;
  localparam logic [1:0] PCG_FETCH = 2'd1;
  localparam logic [1:0] PCG_EXEC  = 2'd2;
  localparam logic [1:0] PCG_TRAP  = 2'd3;

  localparam logic [31:0] PCG_NOP = 32'h0000_0013;

  // pc_src_a selects sequential vs. taken; pc_src_b picks the taken base
  localparam logic PC_SRC_A_SEQ   = 1'b0;
  localparam logic PC_SRC_A_TAKEN = 1'b1;
  localparam logic PC_SRC_B_PC    = 1'b0;
  localparam logic PC_SRC_B_RS1   = 1'b1;

  typedef struct packed {
    logic a;
    logic b;
  } pc_src_t;

  // A control-flow target is word-misaligned when bit 1 is set
  function automatic logic target_misaligned(input logic [1:0] lsbs);
    return lsbs[1];
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Instruction-memory fetch handshake: request/address out, ack/data back.
interface pc_gen_if #(
  parameter int XLEN = 32
) ();

  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic            if_ack;
  logic [31:0]     if_rdata;

  modport master (
    output if_req,
    output if_addr,
    input  if_ack,
    input  if_rdata
  );

  modport slave (
    input  if_req,
    input  if_addr,
    output if_ack,
    output if_rdata
  );

endinterface

// File: rtl/pc_gen_next_pc_calc.sv
// Combinational next-PC selection and misalign detection; kept standalone so
// prediction logic can reuse the same target arithmetic.
module next_pc_calc
  import pc_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic            pc_src_a_i,
  input  logic            pc_src_b_i,
  output logic [XLEN-1:0] next_o,
  output logic            misalign_hit_o
);

  logic [XLEN-1:0] seq_tgt;
  logic [XLEN-1:0] pc_rel_tgt;
  logic [XLEN-1:0] rs1_sum;
  logic [XLEN-1:0] rs1_rel_tgt;

  // All sums wrap modulo 2^XLEN
  assign seq_tgt     = pc_i + XLEN'(4);
  assign pc_rel_tgt  = pc_i + imm_i;
  assign rs1_sum     = rs1_i + imm_i;
  assign rs1_rel_tgt = {rs1_sum[XLEN-1:1], 1'b0};

  always_comb begin
    next_o         = seq_tgt;
    misalign_hit_o = 1'b0;
    if (pc_src_a_i == PC_SRC_A_TAKEN) begin
      if (pc_src_b_i == PC_SRC_B_RS1) begin
        next_o = rs1_rel_tgt;
      end else begin
        next_o = pc_rel_tgt;
      end
      misalign_hit_o = target_misaligned(next_o[1:0]);
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program counter and fetch sequencer: holds the PC, runs the fetch
// handshake, latches the instruction and traps on misaligned targets.
//
//   state     | meaning
//   ----------+-------------------------------------------------
//   PCG_BOOT  | one idle cycle after reset, no request
//   PCG_FETCH | if_req high at pc, waiting for if_ack
//   PCG_EXEC  | instr valid, waiting for commit to pick next pc
//   PCG_TRAP  | misaligned target seen, waiting for trap_clr
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100)
) (
  input  logic            clk,
  input  logic            rst,
  pc_gen_if.master        fetch,
  input  logic            pc_src_a_i,
  input  logic            pc_src_b_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic            commit_i,
  input  logic            trap_clr_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic [31:0]     instr_o,
  output logic            instr_valid_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] bad_addr_o
);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] bad_addr_q, bad_addr_d;

  logic [XLEN-1:0] calc_next;
  logic            calc_misalign;

  next_pc_calc #(
    .XLEN (XLEN)
  ) u_next_pc_calc (
    .pc_i           (pc_q),
    .imm_i          (imm_i),
    .rs1_i          (rs1_i),
    .pc_src_a_i     (pc_src_a_i),
    .pc_src_b_i     (pc_src_b_i),
    .next_o         (calc_next),
    .misalign_hit_o (calc_misalign)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    bad_addr_d = bad_addr_q;
    case (state_q)
      PCG_BOOT: begin
        state_d = PCG_FETCH;
      end
      PCG_FETCH: begin
        if (fetch.if_ack) begin
          instr_d = fetch.if_rdata;
          state_d = PCG_EXEC;
        end
      end
      PCG_EXEC: begin
        if (commit_i) begin
          if (calc_misalign) begin
            bad_addr_d = calc_next;
            state_d    = PCG_TRAP;
          end else begin
            pc_d    = calc_next;
            state_d = PCG_FETCH;
          end
        end
      end
      PCG_TRAP: begin
        if (trap_clr_i) begin
          pc_d    = TRAP_VEC;
          state_d = PCG_FETCH;
        end
      end
      default: begin
        state_d = PCG_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PCG_BOOT;
      pc_q       <= RESET_VEC;
      instr_q    <= PCG_NOP;
      bad_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      bad_addr_q <= bad_addr_d;
    end
  end

  // Handshake and status flags are pure state decodes, so reset clears them
  assign fetch.if_req   = (state_q == PCG_FETCH);
  assign fetch.if_addr  = pc_q;
  assign pc_o           = pc_q;
  assign pc_plus4_o     = pc_q + XLEN'(4);
  assign instr_o        = instr_q;
  assign instr_valid_o  = (state_q == PCG_EXEC);
  assign misalign_o     = (state_q == PCG_TRAP);
  assign bad_addr_o     = bad_addr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: expected fetch addresses and instructions are
// queued as stimulus is driven and popped when the DUT presents them.
module tb_pc_gen;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            pc_src_a = 1'b0;
  logic            pc_src_b = 1'b0;
  logic [XLEN-1:0] imm = '0;
  logic [XLEN-1:0] rs1 = '0;
  logic            commit = 1'b0;
  logic            trap_clr = 1'b0;

  logic [XLEN-1:0] pc, pc_plus4, bad_addr;
  logic [31:0]     instr;
  logic            instr_valid, misalign;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_instr_q[$];
  logic [31:0] last_instr = 32'h0000_0013;

  pc_gen_if #(.XLEN(XLEN)) bus ();

  pc_gen #(
    .XLEN      (XLEN),
    .RESET_VEC (32'h0000_0000),
    .TRAP_VEC  (32'h0000_0100)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch         (bus),
    .pc_src_a_i    (pc_src_a),
    .pc_src_b_i    (pc_src_b),
    .imm_i         (imm),
    .rs1_i         (rs1),
    .commit_i      (commit),
    .trap_clr_i    (trap_clr),
    .pc_o          (pc),
    .pc_plus4_o    (pc_plus4),
    .instr_o       (instr),
    .instr_valid_o (instr_valid),
    .misalign_o    (misalign),
    .bad_addr_o    (bad_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pc"}, pc, 32'h0000_0000);
    check({tag, "_req"}, {31'd0, bus.if_req}, 32'd0);
    check({tag, "_instr"}, instr, 32'h0000_0013);
    check({tag, "_ivalid"}, {31'd0, instr_valid}, 32'd0);
    check({tag, "_misalign"}, {31'd0, misalign}, 32'd0);
    check({tag, "_bad_addr"}, bad_addr, 32'h0000_0000);
  endtask

  // Expects the DUT in (or about to enter) FETCH; acks after 'delay' idle cycles.
  task automatic fetch_cycle(input int delay, input logic [31:0] data);
    logic [31:0] ea;
    int n = 0;
    while (bus.if_req !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    check("fetch_req", {31'd0, bus.if_req}, 32'd1);
    ea = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : 32'hxxxx_xxxx;
    check("fetch_addr", bus.if_addr, ea);
    exp_instr_q.push_back(data);
    for (int i = 0; i < delay; i++) begin
      bus.if_ack   = 1'b0;
      bus.if_rdata = $urandom;
      tick();
      check("hold_req", {31'd0, bus.if_req}, 32'd1);
      check("hold_addr", bus.if_addr, ea);
      check("hold_ivalid", {31'd0, instr_valid}, 32'd0);
      check("hold_instr", instr, last_instr);
    end
    bus.if_ack   = 1'b1;
    bus.if_rdata = data;
    tick();
    bus.if_ack   = 1'b0;
    bus.if_rdata = 32'hDEAD_BEEF;
    check("exec_ivalid", {31'd0, instr_valid}, 32'd1);
    check("fetch_instr", instr, exp_instr_q.pop_front());
    last_instr = data;
  endtask

  task automatic do_commit(input logic a, input logic b, input logic [31:0] imm_v,
                           input logic [31:0] rs1_v, input logic [31:0] exp_next,
                           input logic exp_trap);
    logic [31:0] pc_before;
    pc_before = pc;
    pc_src_a = a;
    pc_src_b = b;
    imm      = imm_v;
    rs1      = rs1_v;
    commit   = 1'b1;
    tick();
    commit   = 1'b0;
    pc_src_a = 1'b1;
    pc_src_b = 1'b1;
    imm      = $urandom;
    rs1      = $urandom;
    if (!exp_trap) begin
      exp_addr_q.push_back(exp_next);
      check("commit_pc", pc, exp_next);
      check("commit_misalign", {31'd0, misalign}, 32'd0);
    end else begin
      check("trap_misalign", {31'd0, misalign}, 32'd1);
      check("trap_bad_addr", bad_addr, exp_next);
      check("trap_pc", pc, pc_before);
      check("trap_req", {31'd0, bus.if_req}, 32'd0);
      check("trap_ivalid", {31'd0, instr_valid}, 32'd0);
    end
  endtask

  initial begin
    bus.if_ack   = 1'b0;
    bus.if_rdata = 32'h0;

    // Reset state
    tick();
    tick();
    check_reset("reset");

    // Release with if_ack tied high: one BOOT cycle, then fetch from 0
    bus.if_ack   = 1'b1;
    bus.if_rdata = 32'h0000_0093;
    rst = 1'b0;
    check("boot_req", {31'd0, bus.if_req}, 32'd0);
    tick();
    check("boot_instr_unchanged", instr, 32'h0000_0013);
    exp_addr_q.push_back(32'h0000_0000);
    fetch_cycle(0, 32'h0000_0093);

    // EXEC holds without commit; trap_clr outside TRAP ignored
    trap_clr = 1'b1;
    pc_src_a = 1'b1;
    imm      = 32'h0000_0040;
    tick();
    tick();
    trap_clr = 1'b0;
    check("exec_hold_pc", pc, 32'h0000_0000);
    check("exec_hold_ivalid", {31'd0, instr_valid}, 32'd1);

    // Branch to 0x40, then sequential to 0x44 with a slow fetch
    do_commit(1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h0000_0040, 1'b0);
    fetch_cycle(0, 32'h0400_006F);
    do_commit(1'b0, 1'b0, 32'h0000_1000, 32'h0, 32'h0000_0044, 1'b0);
    check("seq_pc_plus4", pc_plus4, 32'h0000_0048);
    fetch_cycle(3, 32'h0010_0113);

    // JALR to 0x100, backward branch to 0xF0, JALR with odd sum to 0x2004
    do_commit(1'b1, 1'b1, 32'h0000_0000, 32'h0000_0100, 32'h0000_0100, 1'b0);
    fetch_cycle(1, 32'h1111_1111);
    do_commit(1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0, 32'h0000_00F0, 1'b0);
    fetch_cycle(0, 32'h2222_2222);
    do_commit(1'b1, 1'b1, 32'h0000_0003, 32'h0000_2001, 32'h0000_2004, 1'b0);
    fetch_cycle(2, 32'h3333_3333);

    // Misaligned branch from 0x80
    do_commit(1'b1, 1'b1, 32'h0000_0000, 32'h0000_0080, 32'h0000_0080, 1'b0);
    fetch_cycle(0, 32'h4444_4444);
    do_commit(1'b1, 1'b0, 32'h0000_0006, 32'h0, 32'h0000_0086, 1'b1);
    check("trap_pc_plus4", pc_plus4, 32'h0000_0084);
    pc_src_a = 1'b0;
    commit   = 1'b1;
    tick();
    commit   = 1'b0;
    check("trap_commit_ignored_pc", pc, 32'h0000_0080);
    check("trap_commit_ignored_mis", {31'd0, misalign}, 32'd1);
    bus.if_ack = 1'b1;
    tick();
    bus.if_ack = 1'b0;
    check("trap_ack_ignored_req", {31'd0, bus.if_req}, 32'd0);
    check("trap_ack_ignored_instr", instr, 32'h4444_4444);
    trap_clr = 1'b1;
    tick();
    trap_clr = 1'b0;
    check("trap_clr_pc", pc, 32'h0000_0100);
    check("trap_clr_misalign", {31'd0, misalign}, 32'd0);
    check("trap_clr_bad_addr_held", bad_addr, 32'h0000_0086);
    exp_addr_q.push_back(32'h0000_0100);
    fetch_cycle(0, 32'h5555_5555);

    // Wrap-around: 0xFFFF_FFFC + 4 -> 0
    do_commit(1'b1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
    check("wrap_pre_pc_plus4", pc_plus4, 32'h0000_0000);
    fetch_cycle(0, 32'h6666_6666);
    do_commit(1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0000, 1'b0);
    check("wrap_pc_plus4", pc_plus4, 32'h0000_0004);
    fetch_cycle(0, 32'h7777_7777);

    // Reset in the middle of an un-acked fetch
    do_commit(1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0004, 1'b0);
    exp_addr_q.delete();
    tick();
    check("midfetch_req", {31'd0, bus.if_req}, 32'd1);
    rst = 1'b1;
    tick();
    check_reset("rst_midfetch");
    last_instr = 32'h0000_0013;

    // Reset while in TRAP
    rst = 1'b0;
    check("reboot_req", {31'd0, bus.if_req}, 32'd0);
    tick();
    exp_addr_q.push_back(32'h0000_0000);
    fetch_cycle(0, 32'h8888_8888);
    do_commit(1'b1, 1'b0, 32'h0000_0002, 32'h0, 32'h0000_0002, 1'b1);
    rst = 1'b1;
    tick();
    check_reset("rst_midtrap");
    rst = 1'b0;
    tick();
    tick();
    check("post_reset_fetch_addr", bus.if_addr, 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Program-counter and fetch-sequencing stage that consumes the branch controller's pc_src_a/pc_src_b decision and produces the next PC.
- Holds the architectural PC and drives a valid/ack fetch handshake to instruction memory.
- Latches the fetched instruction for decode and traps on misaligned control-flow targets.
- Sits between the branch controller / ALU (upstream) and the instruction memory port and decode (downstream).

Parameters:
- XLEN, 32: datapath and address width.
- RESET_VEC, 32'h0000_0000: PC loaded on reset.
- TRAP_VEC, 32'h0000_0100: PC loaded when a misalign trap is cleared.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-high.
- pc_src_a  in  1  0 = sequential (PC+4), 1 = taken/jump.
- pc_src_b  in  1  only meaningful when pc_src_a=1: 0 = PC+imm, 1 = rs1+imm.
- imm  in  XLEN  sign-extended immediate from decode.
- rs1  in  XLEN  register-file rs1 value.
- commit  in  1  current instruction retires this cycle; PC advances.
- if_ack  in  1  instruction memory returns data this cycle.
- if_rdata  in  32  fetched instruction word.
- trap_clr  in  1  trap handler acknowledges the misalign trap.
- if_req  out  1  fetch request valid.
- if_addr  out  XLEN  fetch address (equals pc).
- pc  out  XLEN  current PC.
- pc_plus4  out  XLEN  pc+4, combinational, for JAL/JALR link writeback.
- instr  out  32  latched instruction.
- instr_valid  out  1  instr is valid, and the stage is waiting for commit.
- misalign  out  1  high in TRAP state.
- bad_addr  out  XLEN  offending target, captured on trap entry.

Behaviour:
- Reset (synchronous, any state, overrides every other input):
  - pc=RESET_VEC; state=BOOT.
  - if_req=0, instr=32'h0000_0013 (NOP), instr_valid=0, misalign=0, bad_addr=0.
- States: BOOT, FETCH, EXEC, TRAP. State is encoded in 2 bits.
- BOOT: lasts exactly one cycle after reset deasserts; no request issued; then goes to FETCH.
- FETCH:
  - if_req=1, if_addr=pc.
  - if_ack=0: hold, with if_req held high and if_addr stable.
  - if_ack=1: instr<=if_rdata, then go to EXEC.
  - Minimum fetch latency is 1 cycle: if_req is high on cycle N, and if_ack on N gives instr_valid on N+1.
  - if_ack while not in FETCH is ignored.
- EXEC:
  - instr_valid=1. pc_src_a, pc_src_b, imm and rs1 are sampled only in the cycle commit=1.
  - Target selection:
    - pc_src_a=0: next=pc+4.
    - a=1, b=0: next=pc+imm.
    - a=1, b=1: next=(rs1+imm) with bit0 forced to 0.
  - All sums are modulo 2^XLEN and wrap silently; no overflow flag. Example: 32'hFFFF_FFFC+4 gives 0.
  - Misalign check applies only when a=1, and fires when next[1]==1 after bit0 clearing. When it fires: bad_addr<=next, pc unchanged, go to TRAP.
  - Otherwise: pc<=next, go to FETCH. The next if_req is high on the following cycle.
  - With commit=0, stay in EXEC and hold everything.
- TRAP:
  - misalign=1, if_req=0, instr_valid=0.
  - On trap_clr=1: pc<=TRAP_VEC, misalign<=0, go to FETCH.
  - commit is ignored in TRAP.
- Simultaneous events:
  - rst together with anything: rst wins.
  - trap_clr outside TRAP: ignored.
  - commit outside EXEC: ignored.
- pc_plus4 is always pc+4, combinational, independent of state.

Decomposition:
- Shared core package:
  - State encodings PCG_BOOT=2'd0, PCG_FETCH=2'd1, PCG_EXEC=2'd2, PCG_TRAP=2'd3.
  - NOP constant 32'h0000_0013.
  - pc_src encoding constants shared with the branch controller.
- One sub-module, next_pc_calc: purely combinational. It takes pc, imm, rs1, pc_src_a and pc_src_b, and returns next and misalign_hit. It is reused by any future prediction logic.

Test Plan:
- Reset release with RESET_VEC=0, if_ack tied 1 -> BOOT 1 cycle; if_req rises on the 2nd cycle with if_addr=0; instr_valid is 1 the cycle after.
- Sequential: pc=0x40, commit with a=0 -> pc=0x44, if_addr=0x44, pc_plus4=0x48. Fetch with if_ack delayed 3 cycles -> if_req/if_addr held stable for all 3 cycles, instr captured only on the ack.
- Branch: pc=0x100, a=1, b=0, imm=0xFFFF_FFF0 -> pc=0xF0. JALR: a=1, b=1, rs1=0x2001, imm=0x3 -> pc=0x2004, with bit0 clear and no trap.
- Misalign: pc=0x80, a=1, b=0, imm=0x6 -> misalign=1, bad_addr=0x86, pc stays 0x80, if_req=0. commit during TRAP ignored. trap_clr -> pc=0x100 and fetch from 0x100.
- Wrap: pc=0xFFFF_FFFC, commit with a=0 -> pc=0x0000_0000, no trap.
- Reset mid-fetch (if_req=1, no ack) and mid-TRAP -> next cycle pc=RESET_VEC, state BOOT, all outputs at reset values.
